sipo_word_assembler: RTL and testbench
======================================

// Module: sipo_word_assembler
// PURPOSE
//  Serial-in/parallel-out word assembler placed directly downstream of the dflipflop
//  serial data stage. It collects WIDTH serial bits into a word using a bit counter.
//  It then hands the word to a consumer through a single-entry output register with a
//  valid/ready handshake, and stalls the serial side while that register is occupied.
// PARAMETERS
//  WIDTH      8   data bits per word (>=2)
//  MSB_FIRST  1   1: first accepted bit lands in word_data[WIDTH-1]; 0: first bit lands in [0]
// PORTS
//  clk         in   1                    rising-edge clock
//  rst_n       in   1                    asynchronous active-low reset
//  sin_valid   in   1                    serial bit present on sin_bit
//  sin_bit     in   1                    serial data bit
//  sin_ready   out  1                    assembler can accept a bit this cycle
//  clr         in   1                    sync discard of the partial word (output reg untouched)
//  word_valid  out  1                    word_data holds a complete word
//  word_data   out  WIDTH                assembled word
//  word_ready  in   1                    consumer takes the word this cycle
//  bit_cnt     out  $clog2(WIDTH+2)      bits held in the shift register
//  parity_err  out  1                    parity mismatch for the word in word_data
// BEHAVIOUR
//  - Reset (async, rst_n=0): shift reg=0, bit_cnt=0, word_data=0, word_valid=0,
//    parity_err=0, state=COLLECT, sin_ready=0 while rst_n=0, then 1.
//  - Bit accept = sin_valid & sin_ready at the rising edge. Each accept shifts the bit in
//    (direction set by MSB_FIRST) and increments bit_cnt.
//  - Frame length N = WIDTH (WIDTH+1 with parity).
//  - FSM COLLECT: sin_ready=1. On the accept that makes bit_cnt reach N:
//    - if out_free (= ~word_valid | word_ready), the word moves to word_data in the same
//      edge; word_valid=1, bit_cnt=0, state stays COLLECT;
//    - otherwise bit_cnt=N and state -> STALL.
//  - FSM STALL: sin_ready=0. When out_free: transfer the word, bit_cnt=0, state -> COLLECT.
//  - Latency: word_valid rises on the edge that accepts the last bit if the output register
//    is free, else on the first edge with word_ready=1.
//  - Handshake: word_data/word_valid are held stable while word_valid & ~word_ready.
//    word_valid drops on the take edge unless a new word loads on that same edge
//    (back-to-back, no bubble).
//  - clr=1: bit_cnt=0, shift reg=0, state -> COLLECT. It beats a simultaneous accept (the
//    bit is dropped). In STALL it discards the pending word. The output register is
//    unaffected.
//  - sin_valid while sin_ready=0 is ignored; no bit is lost because the producer must hold
//    the bit.
//  - rst_n asserted mid-word or mid-handshake: everything clears immediately; no partial
//    word is ever presented.
// CONFIGURATION
//  - PARITY_CHECK_EN defined:
//    - frame = WIDTH data bits followed by 1 even-parity bit (N=WIDTH+1);
//    - the parity bit is not stored in word_data;
//    - parity_err = ^{data,parity_bit} latched with the word and valid only while
//      word_valid=1.
//  - PARITY_CHECK_EN undefined: N=WIDTH; parity_err tied 0.
// TESTING
//  - Reset: rst_n=0 mid-frame after 3 bits -> bit_cnt=0, word_valid=0, word_data=0 at once.
//  - WIDTH=8, MSB_FIRST=1, word_ready=1: bits 1,0,1,1,0,0,1,0 -> word_data=8'hB2 with
//    word_valid=1 after the 8th accept edge; MSB_FIRST=0 -> 8'h4D.
//  - Backpressure: word_ready=0 with word 0xB2 held; shift 8 more bits 0xFF -> STALL,
//    sin_ready=0, word_data stays 0xB2. Pulse word_ready -> 0xFF loads on that edge,
//    word_valid stays 1, sin_ready=1 next cycle.
//  - clr after 5 bits, then 8 bits of 0x3C -> word_data=0x3C; clr+sin_valid same cycle ->
//    bit dropped, bit_cnt=0.
//  - PARITY_CHECK_EN: 0xB2 + parity 0 -> parity_err=0; 0xB2 + parity 1 -> parity_err=1
//    with word_data=0xB2.
//  - Random sin_valid/word_ready traffic, 1000 words: scoreboard order and data match,
//    no loss or duplication.

Source files
------------

// File: rtl/sipo_word_assembler.sv
// Serial-in/parallel-out word assembler with a single-entry valid/ready output register.
// Optional even-parity frame bit when PARITY_CHECK_EN is defined.
module sipo_word_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sin_valid,
    input  logic                           sin_bit,
    output logic                           sin_ready,
    input  logic                           clr,
    output logic                           word_valid,
    output logic [WIDTH-1:0]               word_data,
    input  logic                           word_ready,
    output logic [$clog2(WIDTH+2)-1:0]     bit_cnt,
    output logic                           parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH+2);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(N);
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(N-1);

    typedef enum logic {COLLECT, STALL} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       sr_q, sr_d, sr_shift;
    logic [CNT_W-1:0]   cnt_d;
    logic               load;
    logic               out_free;
    logic [WIDTH-1:0]   load_data;

    assign out_free = ~word_valid | word_ready;

    // The data bits always occupy the end of the frame that saw the first bit;
    // the parity bit (if any) sits at the opposite end.
    assign sr_shift  = MSB_FIRST ? {sr_q[N-2:0], sin_bit} : {sin_bit, sr_q[N-1:1]};
    assign load_data = MSB_FIRST ? sr_d[N-1 -: WIDTH] : sr_d[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = bit_cnt;
        load      = 1'b0;
        sin_ready = 1'b0;
        unique case (state_q)
            COLLECT: begin
                sin_ready = rst_n;
                if (clr) begin
                    sr_d  = '0;
                    cnt_d = '0;
                end else if (sin_valid) begin
                    sr_d = sr_shift;
                    if (bit_cnt == PENULT) begin
                        if (out_free) begin
                            load  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d   = LAST;
                            state_d = STALL;
                        end
                    end else begin
                        cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            STALL: begin
                if (clr) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end else if (out_free) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            sr_q    <= '0;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_cnt <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_valid <= 1'b0;
            word_data  <= '0;
        end else if (load) begin
            word_valid <= 1'b1;
            word_data  <= load_data;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    // Reduction over the whole frame equals ^{data, parity_bit}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= ^sr_d;
        end else if (word_ready) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Directed and random self-checking bench for sipo_word_assembler (WIDTH=8).
// A second instance with MSB_FIRST=0 shares the stimulus.
module tb_sipo_word_assembler;

    localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH+2);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sin_valid, sin_bit, clr, word_ready;
    logic             sin_ready, word_valid, parity_err;
    logic [WIDTH-1:0] word_data;
    logic [CNT_W-1:0] bit_cnt;
    logic             l_sin_ready, l_word_valid, l_parity_err;
    logic [WIDTH-1:0] l_word_data;
    logic [CNT_W-1:0] l_bit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo_word_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_ready(sin_ready), .clr(clr), .word_valid(word_valid),
        .word_data(word_data), .word_ready(word_ready), .bit_cnt(bit_cnt),
        .parity_err(parity_err)
    );

    sipo_word_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_ready(l_sin_ready), .clr(clr), .word_valid(l_word_valid),
        .word_data(l_word_data), .word_ready(word_ready), .bit_cnt(l_bit_cnt),
        .parity_err(l_parity_err)
    );

    // Drive one bit and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_bit(input logic b);
        int budget;
        budget    = 200;
        sin_valid = 1'b1;
        sin_bit   = b;
        while (!sin_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_err++;
            $display("FAIL send_bit_timeout: sin_ready stuck at %0b, required 1", sin_ready);
        end else begin
            @(posedge clk); #1;
        end
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input logic p);
        for (int i = WIDTH-1; i >= 0; i--) send_bit(d[i]);
        if (N > WIDTH) send_bit(p);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sin_valid = 1'b0; sin_bit = 1'b0; clr = 1'b0; word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bit_cnt !== '0) begin n_err++; $display("FAIL rst_bit_cnt: got %0d want 0", bit_cnt); end
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rst_word_valid: got %0b want 0", word_valid); end
        n_cmp++; if (word_data !== 8'h00) begin n_err++; $display("FAIL rst_word_data: got %h want 00", word_data); end
        n_cmp++; if (sin_ready !== 1'b0) begin n_err++; $display("FAIL rst_sin_ready: got %0b want 0", sin_ready); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL rst_parity_err: got %0b want 0", parity_err); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (sin_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_sin_ready: got %0b want 1", sin_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send_word(8'hB2, 1'b0);
        n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", word_valid); end
        n_cmp++; if (word_data !== 8'hB2) begin n_err++; $display("FAIL basic_msb_data: got %h want b2", word_data); end
        n_cmp++; if (l_word_data !== 8'h4D) begin n_err++; $display("FAIL basic_lsb_data: got %h want 4d", l_word_data); end
        n_cmp++; if (bit_cnt !== '0) begin n_err++; $display("FAIL basic_bit_cnt: got %0d want 0", bit_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_take_drop: got %0b want 0", word_valid); end
        word_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        send_word(8'hB2, 1'b0);
        send_word(8'hFF, 1'b0);
        n_cmp++; if (sin_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready: got %0b want 0", sin_ready); end
        n_cmp++; if (bit_cnt !== CNT_W'(N)) begin n_err++; $display("FAIL bp_stall_cnt: got %0d want %0d", bit_cnt, N); end
        @(posedge clk); #1;
        n_cmp++; if (word_data !== 8'hB2 || word_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %h/%0b want b2/1", word_data, word_valid); end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        n_cmp++; if (word_data !== 8'hFF || word_valid !== 1'b1) begin n_err++; $display("FAIL bp_b2b_load: got %h/%0b want ff/1", word_data, word_valid); end
        n_cmp++; if (sin_ready !== 1'b1 || bit_cnt !== '0) begin n_err++; $display("FAIL bp_resume: got ready %0b cnt %0d want 1/0", sin_ready, bit_cnt); end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %0b want 0", word_valid); end
    endtask

    task automatic test_clr();
        word_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        n_cmp++; if (bit_cnt !== CNT_W'(5)) begin n_err++; $display("FAIL clr_pre_cnt: got %0d want 5", bit_cnt); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_cmp++; if (bit_cnt !== '0) begin n_err++; $display("FAIL clr_cnt: got %0d want 0", bit_cnt); end
        send_word(8'h3C, 1'b0);
        n_cmp++; if (word_data !== 8'h3C || word_valid !== 1'b1) begin n_err++; $display("FAIL clr_word: got %h/%0b want 3c/1", word_data, word_valid); end
        send_bit(1'b0); send_bit(1'b1);
        clr = 1'b1; sin_valid = 1'b1; sin_bit = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; sin_valid = 1'b0;
        n_cmp++; if (bit_cnt !== '0) begin n_err++; $display("FAIL clr_beats_accept: got %0d want 0", bit_cnt); end
        // clr while stalled discards only the pending word
        word_ready = 1'b0;
        send_word(8'hA5, 1'b0);
        send_word(8'h5A, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_cmp++; if (sin_ready !== 1'b1 || bit_cnt !== '0) begin n_err++; $display("FAIL clr_stall: got ready %0b cnt %0d want 1/0", sin_ready, bit_cnt); end
        n_cmp++; if (word_data !== 8'hA5 || word_valid !== 1'b1) begin n_err++; $display("FAIL clr_stall_out: got %h/%0b want a5/1", word_data, word_valid); end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL clr_stall_discard: got %0b want 0", word_valid); end
    endtask

    task automatic test_reset_midframe();
        word_ready = 1'b0;
        send_word(8'hB2, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        n_cmp++; if (bit_cnt !== CNT_W'(3)) begin n_err++; $display("FAIL mid_pre_cnt: got %0d want 3", bit_cnt); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bit_cnt !== '0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d want 0", bit_cnt); end
        n_cmp++; if (word_valid !== 1'b0 || word_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_out: got %h/%0b want 00/0", word_data, word_valid); end
        n_cmp++; if (sin_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %0b want 0", sin_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        word_ready = 1'b0;
        send_word(8'hB2, 1'b0);
        n_cmp++; if (parity_err !== 1'b0 || word_data !== 8'hB2) begin n_err++; $display("FAIL parity_good: got %0b/%h want 0/b2", parity_err, word_data); end
        word_ready = 1'b1; @(posedge clk); #1; word_ready = 1'b0;
        send_word(8'hB2, 1'b1);
        n_cmp++; if (parity_err !== 1'b1 || word_data !== 8'hB2) begin n_err++; $display("FAIL parity_bad: got %0b/%h want 1/b2", parity_err, word_data); end
        word_ready = 1'b1; @(posedge clk); #1; word_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp_w;
        int got, cyc;
        got = 0; cyc = 0;
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    logic [WIDTH-1:0] d;
                    d = WIDTH'($urandom_range(0, 255));
                    q.push_back(d);
                    for (int i = WIDTH-1; i >= 0; i--) begin
                        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                        send_bit(d[i]);
                    end
                    if (N > WIDTH) send_bit(^d);
                end
            end
            begin
                while (got < 1000 && cyc < 80000) begin
                    word_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    if (word_valid && word_ready) begin
                        n_cmp++;
                        if (q.size() == 0) begin
                            n_err++; $display("FAIL rand_extra_word: got %h want none", word_data);
                        end else begin
                            exp_w = q.pop_front();
                            if (word_data !== exp_w || parity_err !== 1'b0) begin
                                n_err++; $display("FAIL rand_word_%0d: got %h/%0b want %h/0", got, word_data, parity_err, exp_w);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                word_ready = 1'b0;
            end
        join
        n_cmp++; if (got != 1000 || q.size() != 0) begin n_err++; $display("FAIL rand_count: got %0d words (%0d pending) want 1000/0", got, q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clr();
        test_reset_midframe();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
